// File: rtl/exec_ctrl.sv
// Multi-cycle issue/execute controller: decodes one MIPS-style instruction at a time,
// sequences the external ALU through DECODE/EXEC/WB and retires into a 32x32 register file.
module exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_ovfl,
    input  logic        alu_zero,
    output logic        done,
    output logic        illegal,
    output logic        ovfl,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        zero_flag,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_NAND = 6'h28;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] regs [32];

    logic [31:0] instr_q;
    logic [4:0]  dest_q;
    logic        legal_q;
    logic [31:0] result_q;
    logic        ovfl_q;
    logic        zero_q;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    logic [3:0]  dec_ctrl;
    logic        dec_legal;
    logic        dec_itype;
    logic [4:0]  dec_dest;

    logic        accept;
    logic        ovfl_hit;
    logic        commit;

    assign op       = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign funct    = instr_q[5:0];
    assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};

    // Register 0 is forced to read zero even though writes to it are also blocked.
    assign rs_val    = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val    = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign dbg_rdata = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

    assign instr_ready = (state == IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign dec_dest    = dec_itype ? rt : rd;

    // Overflow only matters for add/sub encodings; the ALU flag is noise otherwise.
    assign ovfl_hit = legal_q && ovfl_q && ((alu_ctrl == CTRL_ADD) || (alu_ctrl == CTRL_SUB));
    assign commit   = legal_q && !ovfl_hit && (dest_q != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dec_ctrl  = CTRL_AND;
        dec_legal = 1'b0;
        dec_itype = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_legal = 1'b1;
                case (funct)
                    FN_ADD:  dec_ctrl = CTRL_ADD;
                    FN_SUB:  dec_ctrl = CTRL_SUB;
                    FN_AND:  dec_ctrl = CTRL_AND;
                    FN_OR:   dec_ctrl = CTRL_OR;
                    FN_NOR:  dec_ctrl = CTRL_NOR;
                    FN_NAND: dec_ctrl = CTRL_NAND;
                    FN_SLT:  dec_ctrl = CTRL_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec_ctrl  = CTRL_ADD;
                dec_legal = 1'b1;
                dec_itype = 1'b1;
            end
            OP_SLTI: begin
                dec_ctrl  = CTRL_SLT;
                dec_legal = 1'b1;
                dec_itype = 1'b1;
            end
            default: begin
                dec_ctrl  = CTRL_AND;
                dec_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            instr_q   <= 32'd0;
            dest_q    <= 5'd0;
            legal_q   <= 1'b0;
            result_q  <= 32'd0;
            ovfl_q    <= 1'b0;
            zero_q    <= 1'b0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_ctrl  <= CTRL_AND;
            done      <= 1'b0;
            illegal   <= 1'b0;
            ovfl      <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= 5'd0;
            wb_data   <= 32'd0;
            zero_flag <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            ovfl    <= 1'b0;
            wb_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= instr;
                    end
                    // Debug writes land before DECODE reads, so a same-edge accept sees them.
                    if (dbg_we && (dbg_addr != 5'd0)) begin
                        regs[dbg_addr] <= dbg_wdata;
                    end
                end
                DECODE: begin
                    alu_a    <= rs_val;
                    alu_b    <= dec_itype ? imm_sext : rt_val;
                    alu_ctrl <= dec_ctrl;
                    dest_q   <= dec_dest;
                    legal_q  <= dec_legal;
                end
                EXEC: begin
                    result_q <= alu_out;
                    ovfl_q   <= alu_ovfl;
                    zero_q   <= alu_zero;
                end
                WB: begin
                    if (commit) begin
                        regs[dest_q] <= result_q;
                    end
                    done      <= 1'b1;
                    illegal   <= !legal_q;
                    ovfl      <= ovfl_hit;
                    wb_en     <= commit;
                    wb_reg    <= dest_q;
                    wb_data   <= result_q;
                    zero_flag <= zero_q;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: emulates the external ALU and compares every retire
// against an instruction-level reference model of the register file.
module tb_exec_ctrl;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr       = 32'd0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_ovfl;
    logic        alu_zero;
    logic        done;
    logic        illegal;
    logic        ovfl;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        zero_flag;
    logic        dbg_we      = 1'b0;
    logic [4:0]  dbg_addr    = 5'd0;
    logic [31:0] dbg_wdata   = 32'd0;
    logic [31:0] dbg_rdata;

    logic        junk_ovfl   = 1'b0;
    logic [31:0] mreg [32];
    int          cycle  = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // External ALU; the overflow line carries junk for non add/sub codes.
    always_comb begin
        alu_out  = 32'd0;
        alu_ovfl = junk_ovfl;
        case (alu_ctrl)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: begin
                alu_out  = alu_a + alu_b;
                alu_ovfl = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            4'b0110: begin
                alu_out  = alu_a - alu_b;
                alu_ovfl = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_out = ~(alu_a | alu_b);
            4'b1101: alu_out = ~(alu_a & alu_b);
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_ovfl    (alu_ovfl),
        .alu_zero    (alu_zero),
        .done        (done),
        .illegal     (illegal),
        .ovfl        (ovfl),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata)
    );

    // Instruction-level reference: executes one instruction on mreg.
    task automatic ref_exec(input logic [31:0] ins, output logic legal, output logic e_ovf,
                            output logic e_wben, output logic [4:0] e_dst,
                            output logic [31:0] e_res, output logic [3:0] e_ctrl);
        logic [31:0] a;
        logic [31:0] b;
        longint      wide;
        int          kind;
        a      = mreg[ins[25:21]];
        b      = mreg[ins[20:16]];
        e_dst  = ins[15:11];
        e_res  = 32'd0;
        e_ctrl = 4'b0000;
        legal  = 1'b1;
        wide   = 0;
        kind   = 0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   kind = 1;
                    6'h22:   kind = 2;
                    6'h24:   kind = 3;
                    6'h25:   kind = 4;
                    6'h27:   kind = 5;
                    6'h28:   kind = 6;
                    6'h2A:   kind = 7;
                    default: kind = 0;
                endcase
            end
            6'h08: begin kind = 1; b = {{16{ins[15]}}, ins[15:0]}; e_dst = ins[20:16]; end
            6'h0A: begin kind = 7; b = {{16{ins[15]}}, ins[15:0]}; e_dst = ins[20:16]; end
            default: kind = 0;
        endcase
        case (kind)
            1: begin wide = longint'($signed(a)) + longint'($signed(b)); e_res = a + b; e_ctrl = 4'b0010; end
            2: begin wide = longint'($signed(a)) - longint'($signed(b)); e_res = a - b; e_ctrl = 4'b0110; end
            3: begin e_res = a & b;    e_ctrl = 4'b0000; end
            4: begin e_res = a | b;    e_ctrl = 4'b0001; end
            5: begin e_res = ~(a | b); e_ctrl = 4'b1100; end
            6: begin e_res = ~(a & b); e_ctrl = 4'b1101; end
            7: begin e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e_ctrl = 4'b0111; end
            default: legal = 1'b0;
        endcase
        e_ovf  = ((kind == 1) || (kind == 2)) && ((wide > 64'sd2147483647) || (wide < -64'sd2147483648));
        e_wben = legal && !e_ovf && (e_dst != 5'd0);
        if (e_wben) mreg[e_dst] = e_res;
    endtask

    // Offers one instruction and waits (bounded) for its retire pulse; starts and ends at a negedge.
    task automatic send_instr(input logic [31:0] ins, output int lat, output logic o_ill,
                              output logic o_ovf, output logic o_wben, output logic [4:0] o_reg,
                              output logic [31:0] o_data, output logic o_zero, output logic [3:0] o_ctrl);
        int n;
        int acc;
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        acc = cycle + 1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        lat    = cycle - acc;
        o_ill  = illegal;
        o_ovf  = ovfl;
        o_wben = wb_en;
        o_reg  = wb_reg;
        o_data = wb_data;
        o_zero = zero_flag;
        o_ctrl = alu_ctrl;
    endtask

    task automatic dbg_write(input logic [4:0] addr, input logic [31:0] data);
        dbg_we    = 1'b1;
        dbg_addr  = addr;
        dbg_wdata = data;
        @(negedge clk);
        dbg_we = 1'b0;
        if (addr != 5'd0) mreg[addr] = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_in_reset: got %b, want 0", instr_ready); end
        n_cmp++;
        if ({done, illegal, ovfl, wb_en, zero_flag} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b, want 00000", {done, illegal, ovfl, wb_en, zero_flag});
        end
        n_cmp++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin
            n_fail++; $display("[TB] FAIL reset_alu: got a=%h b=%h ctrl=%b, want zeros", alu_a, alu_b, alu_ctrl);
        end
        n_cmp++;
        if (wb_reg !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_wb: got reg=%0d data=%h, want 0", wb_reg, wb_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_after_reset: got %b, want 1", instr_ready); end
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'd0;
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if (dbg_rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_reg%0d: got %h, want 0", i, dbg_rdata); end
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] prog [9] = '{32'h20010005, 32'h2002FFFD, 32'h00221820, 32'h0041202A,
                                   32'h00E14020, 32'h00E14024, 32'h00214822, 32'h20000007,
                                   32'hFC000000};
        logic [4:0]  chk_reg [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd0};
        logic [31:0] chk_val [7] = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h1, 32'h5, 32'h0, 32'h0};
        int lat;
        logic o_ill, o_ovf, o_wben, o_zero, legal, e_ovf, e_wben;
        logic [4:0] o_reg, e_dst;
        logic [31:0] o_data, e_res;
        logic [3:0] o_ctrl, e_ctrl;
        junk_ovfl = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) dbg_write(5'd7, 32'h7FFFFFFF);
            ref_exec(prog[i], legal, e_ovf, e_wben, e_dst, e_res, e_ctrl);
            send_instr(prog[i], lat, o_ill, o_ovf, o_wben, o_reg, o_data, o_zero, o_ctrl);
            n_cmp++;
            if (lat !== 3) begin n_fail++; $display("[TB] FAIL dir_latency %h: got %0d, want 3", prog[i], lat); end
            n_cmp++;
            if (o_ill !== !legal) begin n_fail++; $display("[TB] FAIL dir_illegal %h: got %b, want %b", prog[i], o_ill, !legal); end
            n_cmp++;
            if (o_ovf !== e_ovf) begin n_fail++; $display("[TB] FAIL dir_ovfl %h: got %b, want %b", prog[i], o_ovf, e_ovf); end
            n_cmp++;
            if (o_wben !== e_wben) begin n_fail++; $display("[TB] FAIL dir_wb_en %h: got %b, want %b", prog[i], o_wben, e_wben); end
            if (e_wben) begin
                n_cmp++;
                if (o_reg !== e_dst || o_data !== e_res) begin
                    n_fail++; $display("[TB] FAIL dir_wb %h: got r%0d=%h, want r%0d=%h", prog[i], o_reg, o_data, e_dst, e_res);
                end
            end
            if (legal) begin
                n_cmp++;
                if (o_zero !== (e_res == 32'd0) || o_ctrl !== e_ctrl) begin
                    n_fail++; $display("[TB] FAIL dir_zero_ctrl %h: got z=%b ctrl=%b, want z=%b ctrl=%b",
                                       prog[i], o_zero, o_ctrl, (e_res == 32'd0), e_ctrl);
                end
            end
            dbg_addr = e_dst;
            #1;
            n_cmp++;
            if (dbg_rdata !== mreg[e_dst]) begin n_fail++; $display("[TB] FAIL dir_reg%0d: got %h, want %h", e_dst, dbg_rdata, mreg[e_dst]); end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL dir_done_width %h: got %b, want 0", prog[i], done); end
        end
        for (int i = 0; i < 7; i++) begin
            dbg_addr = chk_reg[i];
            #1;
            n_cmp++;
            if (dbg_rdata !== chk_val[i]) begin n_fail++; $display("[TB] FAIL dir_final_r%0d: got %h, want %h", chk_reg[i], dbg_rdata, chk_val[i]); end
        end
        junk_ovfl = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_debug_port();
        int n;
        logic legal, e_ovf, e_wben;
        logic [4:0] e_dst;
        logic [31:0] e_res, newv;
        logic [3:0] e_ctrl;
        // Same-edge debug write and accept: DECODE must read the new value.
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'h00001234;
        instr = 32'h216C0001; instr_valid = 1'b1;
        mreg[11] = 32'h00001234;
        ref_exec(32'h216C0001, legal, e_ovf, e_wben, e_dst, e_res, e_ctrl);
        @(negedge clk);
        dbg_we = 1'b0; instr_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        dbg_addr = 5'd12;
        #1;
        n_cmp++;
        if (dbg_rdata !== mreg[12]) begin n_fail++; $display("[TB] FAIL dbg_same_cycle: got %h, want %h", dbg_rdata, mreg[12]); end
        @(negedge clk);
        // Debug write during EXEC must be dropped.
        instr = 32'h200D0003; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = 5'd14; dbg_wdata = 32'hDEADBEEF;
        @(negedge clk);
        dbg_we = 1'b0;
        ref_exec(32'h200D0003, legal, e_ovf, e_wben, e_dst, e_res, e_ctrl);
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        dbg_addr = 5'd14;
        #1;
        n_cmp++;
        if (dbg_rdata !== mreg[14]) begin n_fail++; $display("[TB] FAIL dbg_exec_ignored: got %h, want %h", dbg_rdata, mreg[14]); end
        dbg_addr = 5'd13;
        #1;
        n_cmp++;
        if (dbg_rdata !== mreg[13]) begin n_fail++; $display("[TB] FAIL dbg_exec_instr: got %h, want %h", dbg_rdata, mreg[13]); end
        @(negedge clk);
        // Read port shows the old value until the write edge has passed.
        newv = ~mreg[15];
        dbg_we = 1'b1; dbg_addr = 5'd15; dbg_wdata = newv;
        #1;
        n_cmp++;
        if (dbg_rdata !== mreg[15]) begin n_fail++; $display("[TB] FAIL dbg_read_before: got %h, want %h", dbg_rdata, mreg[15]); end
        @(negedge clk);
        dbg_we = 1'b0;
        mreg[15] = newv;
        #1;
        n_cmp++;
        if (dbg_rdata !== newv) begin n_fail++; $display("[TB] FAIL dbg_read_after: got %h, want %h", dbg_rdata, newv); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4] = '{32'h20100064, 32'h2211FFFF, 32'h02119020, 32'h02509822};
        logic [31:0] want [4] = '{32'd100, 32'd99, 32'd199, 32'd99};
        int acc [4];
        int n;
        logic legal, e_ovf, e_wben;
        logic [4:0] e_dst;
        logic [31:0] e_res;
        logic [3:0] e_ctrl;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = prog[k];
            n = 0;
            while (!instr_ready && n < 20) begin @(negedge clk); n++; end
            acc[k] = cycle + 1;
            ref_exec(prog[k], legal, e_ovf, e_wben, e_dst, e_res, e_ctrl);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (acc[k] - acc[k-1] !== 4) begin
                n_fail++; $display("[TB] FAIL b2b_spacing%0d: got %0d cycles, want 4", k, acc[k] - acc[k-1]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 5'(16 + k);
            #1;
            n_cmp++;
            if (dbg_rdata !== mreg[16 + k] || dbg_rdata !== want[k]) begin
                n_fail++; $display("[TB] FAIL b2b_r%0d: got %h, want %h", 16 + k, dbg_rdata, want[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h28, 6'h2A};
        logic [31:0] ins;
        logic [5:0] opc;
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int sel, lat;
        logic o_ill, o_ovf, o_wben, o_zero, legal, e_ovf, e_wben;
        logic [4:0] o_reg, e_dst;
        logic [31:0] o_data, e_res;
        logic [3:0] o_ctrl, e_ctrl;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) dbg_write(5'($urandom_range(0, 7)), $urandom);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel <= 6) ins = {6'h00, rs, rt, rd, 5'd0, fns[sel]};
            else if (sel == 7) ins = {6'h08, rs, rt, imm};
            else if (sel == 8) ins = {6'h0A, rs, rt, imm};
            else if ($urandom_range(0, 1) == 1) ins = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            else begin
                opc = 6'($urandom_range(1, 63));
                if (opc == 6'h08 || opc == 6'h0A) opc = 6'h3F;
                ins = {opc, rs, rt, imm};
            end
            junk_ovfl = 1'($urandom_range(0, 1));
            ref_exec(ins, legal, e_ovf, e_wben, e_dst, e_res, e_ctrl);
            send_instr(ins, lat, o_ill, o_ovf, o_wben, o_reg, o_data, o_zero, o_ctrl);
            n_cmp++;
            if (lat !== 3) begin n_fail++; $display("[TB] FAIL rnd_latency %h: got %0d, want 3", ins, lat); end
            n_cmp++;
            if (o_ill !== !legal || o_ovf !== e_ovf || o_wben !== e_wben) begin
                n_fail++; $display("[TB] FAIL rnd_flags %h: got ill=%b ov=%b wb=%b, want ill=%b ov=%b wb=%b",
                                   ins, o_ill, o_ovf, o_wben, !legal, e_ovf, e_wben);
            end
            if (e_wben) begin
                n_cmp++;
                if (o_reg !== e_dst || o_data !== e_res) begin
                    n_fail++; $display("[TB] FAIL rnd_wb %h: got r%0d=%h, want r%0d=%h", ins, o_reg, o_data, e_dst, e_res);
                end
            end
            if (legal) begin
                n_cmp++;
                if (o_zero !== (e_res == 32'd0) || o_ctrl !== e_ctrl) begin
                    n_fail++; $display("[TB] FAIL rnd_zero_ctrl %h: got z=%b ctrl=%b, want z=%b ctrl=%b",
                                       ins, o_zero, o_ctrl, (e_res == 32'd0), e_ctrl);
                end
            end
            dbg_addr = e_dst;
            #1;
            n_cmp++;
            if (dbg_rdata !== mreg[e_dst]) begin n_fail++; $display("[TB] FAIL rnd_reg%0d: got %h, want %h", e_dst, dbg_rdata, mreg[e_dst]); end
            @(negedge clk);
        end
        junk_ovfl = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if (dbg_rdata !== mreg[i]) begin n_fail++; $display("[TB] FAIL rnd_sweep_r%0d: got %h, want %h", i, dbg_rdata, mreg[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen_done;
        instr = 32'h20050009; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_ready_in_reset: got %b, want 0", instr_ready); end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ready_after: got %b, want 1", instr_ready); end
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_done: got done pulse, want none"); end
        n_cmp++;
        if ({illegal, ovfl, wb_en, zero_flag} !== 4'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            alu_ctrl !== 4'd0 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++; $display("[TB] FAIL mid_outputs: got a=%h b=%h ctrl=%b wb=%0d/%h flags=%b, want zeros",
                               alu_a, alu_b, alu_ctrl, wb_reg, wb_data, {illegal, ovfl, wb_en, zero_flag});
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if (dbg_rdata !== mreg[i]) begin n_fail++; $display("[TB] FAIL mid_reg%0d: got %h, want 0", i, dbg_rdata); end
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting exec_ctrl bench");
        test_reset();
        test_directed();
        test_debug_port();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
